// File: rtl/mm_pkg.sv
// Shared definitions for the Montgomery-multiplier exponentiation path:
// info-tag values carried alongside each MM op and the sequencer state encoding.
package mm_pkg;

  localparam int unsigned TAG_CONV = 1;
  localparam int unsigned TAG_SQ   = 2;
  localparam int unsigned TAG_MUL  = 3;
  localparam int unsigned TAG_LAD0 = 4;
  localparam int unsigned TAG_LAD1 = 5;
  localparam int unsigned TAG_FIN  = 6;

  // *_W states wait for the tagged return of the op pushed in the preceding state.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CONV,
    ST_CONV_W,
    ST_BIN_SQ,
    ST_BIN_SQ_W,
    ST_BIN_MUL,
    ST_BIN_MUL_W,
    ST_LAD0,
    ST_LAD1,
    ST_LAD_W,
    ST_FIN,
    ST_FIN_W,
    ST_DONE
  } mm_state_e;

endpackage

// File: rtl/mm_issue_slot.sv
// Two-entry operand/tag holding queue in front of the MM core. The head entry is
// presented to the core and retried every cycle until the core is not full.
module mm_issue_slot #(
  parameter int unsigned M_SIZE = 3072,
  parameter int unsigned INFO_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [M_SIZE-1:0] a_i,
  input  logic [M_SIZE-1:0] b_i,
  input  logic [INFO_W-1:0] tag_i,
  input  logic              full_i,
  output logic              en_o,
  output logic [M_SIZE-1:0] a_o,
  output logic [M_SIZE-1:0] b_o,
  output logic [INFO_W-1:0] tag_o
);

  logic [M_SIZE-1:0] head_a_q, head_a_d, head_b_q, head_b_d;
  logic [M_SIZE-1:0] tail_a_q, tail_a_d, tail_b_q, tail_b_d;
  logic [INFO_W-1:0] head_tag_q, head_tag_d, tail_tag_q, tail_tag_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        cnt_after;

  assign en_o  = (cnt_q != 2'd0) && !full_i;
  assign a_o   = head_a_q;
  assign b_o   = head_b_q;
  assign tag_o = head_tag_q;

  always_comb begin
    head_a_d   = head_a_q;
    head_b_d   = head_b_q;
    head_tag_d = head_tag_q;
    tail_a_d   = tail_a_q;
    tail_b_d   = tail_b_q;
    tail_tag_d = tail_tag_q;
    cnt_after  = cnt_q - {1'b0, en_o};

    if (en_o && (cnt_q == 2'd2)) begin
      head_a_d   = tail_a_q;
      head_b_d   = tail_b_q;
      head_tag_d = tail_tag_q;
    end

    cnt_d = cnt_after;
    if (push_i) begin
      if (cnt_after == 2'd0) begin
        head_a_d   = a_i;
        head_b_d   = b_i;
        head_tag_d = tag_i;
      end else begin
        tail_a_d   = a_i;
        tail_b_d   = b_i;
        tail_tag_d = tag_i;
      end
      cnt_d = cnt_after + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_a_q   <= '0;
      head_b_q   <= '0;
      head_tag_q <= '0;
      tail_a_q   <= '0;
      tail_b_q   <= '0;
      tail_tag_q <= '0;
      cnt_q      <= '0;
    end else begin
      head_a_q   <= head_a_d;
      head_b_q   <= head_b_d;
      head_tag_q <= head_tag_d;
      tail_a_q   <= tail_a_d;
      tail_b_q   <= tail_b_d;
      tail_tag_q <= tail_tag_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: rtl/mm_modexp_ctrl.sv
// Modular-exponentiation sequencer driving a pipelined Montgomery multiplier:
// binary left-to-right square-and-multiply or constant-time Montgomery ladder.
module mm_modexp_ctrl
  import mm_pkg::*;
#(
  parameter int unsigned M_SIZE = 3072,
  parameter int unsigned E_W    = 64,
  parameter int unsigned INFO_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [E_W-1:0]    exp,
  input  logic [M_SIZE-1:0] base,
  input  logic [M_SIZE-1:0] r2,
  input  logic [M_SIZE-1:0] one_m,
  output logic              busy,
  output logic              done,
  output logic [M_SIZE-1:0] result,
  output logic              err,
  output logic [CNT_W-1:0]  op_cnt,
  output logic              mm_en,
  output logic [M_SIZE-1:0] mm_a,
  output logic [M_SIZE-1:0] mm_b,
  output logic [INFO_W-1:0] mm_info_o,
  input  logic              mm_full,
  input  logic              mm_done,
  input  logic [M_SIZE-1:0] mm_c,
  input  logic [INFO_W-1:0] mm_info_i
);

  localparam int unsigned BIT_W = (E_W > 1) ? $clog2(E_W) : 1;

  localparam logic [INFO_W-1:0] T_CONV = INFO_W'(TAG_CONV);
  localparam logic [INFO_W-1:0] T_SQ   = INFO_W'(TAG_SQ);
  localparam logic [INFO_W-1:0] T_MUL  = INFO_W'(TAG_MUL);
  localparam logic [INFO_W-1:0] T_LAD0 = INFO_W'(TAG_LAD0);
  localparam logic [INFO_W-1:0] T_LAD1 = INFO_W'(TAG_LAD1);
  localparam logic [INFO_W-1:0] T_FIN  = INFO_W'(TAG_FIN);

  mm_state_e         state_q, state_d;
  logic              mode_q, mode_d;
  logic [E_W-1:0]    exp_q, exp_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [M_SIZE-1:0] r0_q, r0_d, r1_q, r1_d;
  logic [M_SIZE-1:0] result_q, result_d;
  logic [1:0]        pend_q, pend_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              push;
  logic [M_SIZE-1:0] push_a, push_b;
  logic [INFO_W-1:0] push_tag;
  logic              cur_bit, last_bit, tag_ok;
  mm_state_e         step_state;

  assign cur_bit    = exp_q[E_W-1];
  assign last_bit   = (bit_q == '0);
  assign step_state = last_bit ? ST_FIN : (mode_q ? ST_LAD0 : ST_BIN_SQ);

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign err    = err_q;
  assign op_cnt = cnt_q;

  // R0 doubles as the binary accumulator and R1 as base_m; R1 also parks the raw
  // base between start and the conversion issue.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    exp_d    = exp_q;
    bit_d    = bit_q;
    r0_d     = r0_q;
    r1_d     = r1_q;
    result_d = result_q;
    pend_d   = pend_q;
    err_d    = err_q;
    cnt_d    = mm_en ? cnt_q + CNT_W'(1) : cnt_q;
    push     = 1'b0;
    push_a   = r0_q;
    push_b   = r1_q;
    push_tag = T_CONV;
    tag_ok   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tag_ok = 1'b1;
        if (start) begin
          mode_d  = mode;
          exp_d   = exp;
          r1_d    = base;
          bit_d   = BIT_W'(E_W - 1);
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        push     = 1'b1;
        push_a   = r1_q;
        push_b   = r2;
        push_tag = T_CONV;
        state_d  = ST_CONV_W;
      end
      ST_CONV_W: begin
        if (mm_done && (mm_info_i == T_CONV)) begin
          tag_ok  = 1'b1;
          r0_d    = one_m;
          r1_d    = mm_c;
          state_d = mode_q ? ST_LAD0 : ST_BIN_SQ;
        end
      end
      ST_BIN_SQ: begin
        push     = 1'b1;
        push_a   = r0_q;
        push_b   = r0_q;
        push_tag = T_SQ;
        state_d  = ST_BIN_SQ_W;
      end
      ST_BIN_SQ_W: begin
        if (mm_done && (mm_info_i == T_SQ)) begin
          tag_ok = 1'b1;
          r0_d   = mm_c;
          if (cur_bit) begin
            state_d = ST_BIN_MUL;
          end else begin
            exp_d   = exp_q << 1;
            bit_d   = bit_q - BIT_W'(1);
            state_d = step_state;
          end
        end
      end
      ST_BIN_MUL: begin
        push     = 1'b1;
        push_a   = r0_q;
        push_b   = r1_q;
        push_tag = T_MUL;
        state_d  = ST_BIN_MUL_W;
      end
      ST_BIN_MUL_W: begin
        if (mm_done && (mm_info_i == T_MUL)) begin
          tag_ok  = 1'b1;
          r0_d    = mm_c;
          exp_d   = exp_q << 1;
          bit_d   = bit_q - BIT_W'(1);
          state_d = step_state;
        end
      end
      ST_LAD0: begin
        push     = 1'b1;
        push_a   = r0_q;
        push_b   = r1_q;
        push_tag = cur_bit ? T_LAD0 : T_LAD1;
        pend_d   = 2'b11;
        state_d  = ST_LAD1;
      end
      ST_LAD1: begin
        push     = 1'b1;
        push_a   = cur_bit ? r1_q : r0_q;
        push_b   = cur_bit ? r1_q : r0_q;
        push_tag = cur_bit ? T_LAD1 : T_LAD0;
        state_d  = ST_LAD_W;
      end
      ST_LAD_W: begin
        if (mm_done) begin
          if ((mm_info_i == T_LAD0) && pend_q[0]) begin
            tag_ok    = 1'b1;
            r0_d      = mm_c;
            pend_d[0] = 1'b0;
          end else if ((mm_info_i == T_LAD1) && pend_q[1]) begin
            tag_ok    = 1'b1;
            r1_d      = mm_c;
            pend_d[1] = 1'b0;
          end
          if (tag_ok && (pend_d == 2'b00)) begin
            exp_d   = exp_q << 1;
            bit_d   = bit_q - BIT_W'(1);
            state_d = step_state;
          end
        end
      end
      ST_FIN: begin
        push     = 1'b1;
        push_a   = r0_q;
        push_b   = M_SIZE'(1);
        push_tag = T_FIN;
        state_d  = ST_FIN_W;
      end
      ST_FIN_W: begin
        if (mm_done && (mm_info_i == T_FIN)) begin
          tag_ok   = 1'b1;
          result_d = mm_c;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (mm_done && !tag_ok) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= 1'b0;
      exp_q    <= '0;
      bit_q    <= '0;
      r0_q     <= '0;
      r1_q     <= '0;
      result_q <= '0;
      pend_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      exp_q    <= exp_d;
      bit_q    <= bit_d;
      r0_q     <= r0_d;
      r1_q     <= r1_d;
      result_q <= result_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  mm_issue_slot #(
    .M_SIZE (M_SIZE),
    .INFO_W (INFO_W)
  ) u_slot (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (push),
    .a_i    (push_a),
    .b_i    (push_b),
    .tag_i  (push_tag),
    .full_i (mm_full),
    .en_o   (mm_en),
    .a_o    (mm_a),
    .b_o    (mm_b),
    .tag_o  (mm_info_o)
  );

endmodule

// File: tb/tb_mm_modexp_ctrl.sv
// Directed bench for mm_modexp_ctrl with a behavioural Montgomery core (m = 0xF1,
// R = 2^16) that returns a*b*R^-1 mod m after 3-12 cycles.
module tb_mm_modexp_ctrl;

  localparam int unsigned M_SIZE = 16;
  localparam int unsigned E_W    = 8;
  localparam int unsigned INFO_W = 4;
  localparam int unsigned CNT_W  = 16;
  localparam longint unsigned MOD = 241;

  logic              clk = 1'b0;
  logic              rst, start, mode;
  logic [E_W-1:0]    exp_v;
  logic [M_SIZE-1:0] base, r2, one_m;
  logic              busy, done, err;
  logic [M_SIZE-1:0] result;
  logic [CNT_W-1:0]  op_cnt;
  logic              mm_en;
  logic [M_SIZE-1:0] mm_a, mm_b, mm_c;
  logic [INFO_W-1:0] mm_info_o, mm_info_i;
  logic              mm_full, mm_done;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  longint unsigned rinv;

  logic lad1_first  = 1'b0;
  logic inject_req  = 1'b0;
  logic inject_done = 1'b0;
  int   en_while_full = 0;
  int   cyc = 0;

  typedef struct {
    logic [M_SIZE-1:0] c;
    logic [INFO_W-1:0] tag;
    int                due;
  } ret_t;
  ret_t rq[$];

  always #5 clk = ~clk;

  mm_modexp_ctrl #(
    .M_SIZE (M_SIZE),
    .E_W    (E_W),
    .INFO_W (INFO_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .exp       (exp_v),
    .base      (base),
    .r2        (r2),
    .one_m     (one_m),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .err       (err),
    .op_cnt    (op_cnt),
    .mm_en     (mm_en),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_info_o (mm_info_o),
    .mm_full   (mm_full),
    .mm_done   (mm_done),
    .mm_c      (mm_c),
    .mm_info_i (mm_info_i)
  );

  function automatic logic [M_SIZE-1:0] mont(input logic [M_SIZE-1:0] a, input logic [M_SIZE-1:0] b);
    longint unsigned p;
    p = a;
    p = (p * b) % MOD;
    p = (p * rinv) % MOD;
    return M_SIZE'(p);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Core model: record issues, return results by due cycle, one per cycle.
  initial begin
    int best;
    int lat;
    ret_t r;
    mm_done   = 1'b0;
    mm_c      = '0;
    mm_info_i = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (mm_en && mm_full) en_while_full++;
      if (mm_en && !mm_full) begin
        lat = int'($urandom_range(3, 12));
        if (lad1_first && mm_info_o == 4'd4) lat = 12;
        if (lad1_first && mm_info_o == 4'd5) lat = 3;
        if (inject_req && !inject_done && mm_info_o == 4'd2) begin
          r.c = 16'hDEAD; r.tag = 4'd6; r.due = cyc + 2;
          rq.push_back(r);
          lat = 6;
          inject_done = 1'b1;
        end
        r.c = mont(mm_a, mm_b); r.tag = mm_info_o; r.due = cyc + lat;
        rq.push_back(r);
      end
      mm_done = 1'b0;
      best = -1;
      foreach (rq[k]) begin
        if (rq[k].due <= cyc && (best < 0 || rq[k].due < rq[best].due)) best = k;
      end
      if (best >= 0) begin
        mm_done   = 1'b1;
        mm_c      = rq[best].c;
        mm_info_i = rq[best].tag;
        rq.delete(best);
      end
    end
  end

  task automatic start_job(input logic m, input logic [E_W-1:0] e, input logic [M_SIZE-1:0] b);
    @(negedge clk);
    mode  = m;
    exp_v = e;
    base  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
  endtask

  task automatic job(input string tag, input logic m, input logic [E_W-1:0] e,
                     input logic [M_SIZE-1:0] b, input logic [M_SIZE-1:0] want_res,
                     input logic [CNT_W-1:0] want_cnt);
    start_job(m, e, b);
    wait_done(tag);
    check({tag, "_res"}, 32'(result), 32'(want_res));
    check({tag, "_cnt"}, 32'(op_cnt), 32'(want_cnt));
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (longint unsigned x = 1; x < MOD; x++) begin
      if (((x * 65536) % MOD) == 1) rinv = x;
    end
    one_m   = M_SIZE'(65536 % MOD);
    r2      = M_SIZE'((65536 % MOD) * (65536 % MOD) % MOD);
    rst     = 1'b1;
    start   = 1'b0;
    mode    = 1'b0;
    exp_v   = '0;
    base    = '0;
    mm_full = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_err",    32'(err),    32'd0);
    check("rst_opcnt",  32'(op_cnt), 32'd0);
    check("rst_mm_en",  32'(mm_en),  32'd0);
    check("rst_result", 32'(result), 32'd0);

    job("bin_3_0d", 1'b0, 8'h0D, 16'd3, 16'h006C, 16'd13);
    // start during the done cycle must be ignored
    start = 1'b1; mode = 1'b1; exp_v = 8'hFF; base = 16'd7;
    @(negedge clk);
    start = 1'b0;
    check("dn_start_busy", 32'(busy), 32'd0);
    check("dn_start_done", 32'(done), 32'd0);
    check("dn_start_cnt",  32'(op_cnt), 32'd13);
    @(negedge clk);
    check("dn_start_busy2", 32'(busy), 32'd0);

    lad1_first = 1'b1;
    job("lad_3_0d", 1'b1, 8'h0D, 16'd3, 16'h006C, 16'd18);
    lad1_first = 1'b0;

    job("bin_5_00", 1'b0, 8'h00, 16'd5, 16'h0001, 16'd10);
    job("lad_5_00", 1'b1, 8'h00, 16'd5, 16'h0001, 16'd18);
    job("bin_5_01", 1'b0, 8'h01, 16'd5, 16'h0005, 16'd11);
    job("lad_5_01", 1'b1, 8'h01, 16'd5, 16'h0005, 16'd18);

    // core back-pressure mid-job
    start_job(1'b0, 8'h0D, 16'd3);
    repeat (30) @(negedge clk);
    mm_full = 1'b1;
    repeat (20) @(negedge clk);
    mm_full = 1'b0;
    wait_done("full");
    check("full_en_while_full", 32'(en_while_full), 32'd0);
    check("full_res", 32'(result), 32'h006C);
    check("full_cnt", 32'(op_cnt), 32'd13);

    // reset in the middle of a ladder job
    start_job(1'b1, 8'h0D, 16'd3);
    repeat (40) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy",  32'(busy),   32'd0);
    check("mid_rst_opcnt", 32'(op_cnt), 32'd0);
    repeat (30) @(negedge clk);
    check("stale_err", 32'(err), 32'd0);
    job("post_rst", 1'b1, 8'h0D, 16'd3, 16'h006C, 16'd18);

    // unexpected tag during a square wait
    inject_req = 1'b1;
    start_job(1'b0, 8'h0D, 16'd3);
    wait_done("inj");
    check("inj_err",  32'(err),    32'd1);
    check("inj_res",  32'(result), 32'h006C);
    check("inj_cnt",  32'(op_cnt), 32'd13);
    check("inj_used", 32'(inject_done), 32'd1);
    inject_req = 1'b0;
    start_job(1'b0, 8'h01, 16'd5);
    check("inj_clr_err", 32'(err), 32'd0);
    wait_done("inj_next");
    check("inj_next_res", 32'(result), 32'h0005);
    check("inj_next_err", 32'(err),    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
